// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Holds the stage-state encoding and the default payload widths.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_RD_W   = 5;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register built as a 2-entry skid buffer (main + skid register).
// Handshake: a beat moves when valid and ready are both 1 on the same rising edge;
// valid never waits on ready, and a presented beat holds stable until it is taken.
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int RD_W   = DEF_RD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam int PW = CTRL_W + RD_W + DATA_W;

  stage_state_t  state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          ready_q;
  logic          push, pop;
  logic [PW-1:0] in_beat;

  assign in_beat = {in_ctrl, in_rd, in_data};
  assign push    = in_valid & ready_q;
  assign pop     = (state_q != ST_EMPTY) & out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      // Registered so in_ready has no combinational path from out_ready.
      ready_q <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_d  = in_beat;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d = in_beat;
          end else if (push) begin
            skid_d  = in_beat;
            state_d = ST_TWO;
          end else if (pop) begin
            // Zeroed main register presents a bubble (ctrl=0) downstream.
            main_d  = '0;
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
  assign {out_ctrl, out_rd, out_data} = main_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks for the pipe_stage_reg skid buffer.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int RD_W   = 5;
  localparam int PW     = CTRL_W + RD_W + DATA_W;

  logic              clock;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [RD_W-1:0]   in_rd;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [RD_W-1:0]   out_rd;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_rd(out_rd), .out_data(out_data),
    .occupancy(occupancy)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks: inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic [CTRL_W-1:0] c,
                       input logic [RD_W-1:0] d, input logic [DATA_W-1:0] x);
    in_valid  = v;
    out_ready = r;
    in_ctrl   = c;
    in_rd     = d;
    in_data   = x;
  endtask

  task automatic do_reset();
    flush = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 ||
        out_ctrl !== '0 || out_rd !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b occ=%0d ctrl=%h rd=%h data=%h, want 0 1 0 0 0 0",
               out_valid, in_ready, occupancy, out_ctrl, out_rd, out_data);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 1'b1, 8'h0F, 5'd9, 32'hDEADBEEF);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_ctrl !== 8'h0F || out_rd !== 5'd9 ||
        out_data !== 32'hDEADBEEF || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL single: valid=%b ctrl=%h rd=%0d data=%h ready=%b occ=%0d, want 1 0f 9 deadbeef 1 1",
               out_valid, out_ctrl, out_rd, out_data, in_ready, occupancy);
    end
    drive(1'b0, 1'b1, '0, '0, '0);
    step();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL single_drain: valid=%b ctrl=%h data=%h occ=%0d, want 0 00 0 0",
               out_valid, out_ctrl, out_data, occupancy);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b1, 8'(k + 8'h10), 5'(k), 32'(k));
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(k) || out_ctrl !== 8'(k + 8'h10) ||
          in_ready !== 1'b1 || occupancy !== 2'd1) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b data=%0d ctrl=%h ready=%b occ=%0d, want 1 %0d %h 1 1",
                 k, out_valid, out_data, out_ctrl, in_ready, occupancy, k, 8'(k + 8'h10));
      end
    end
    drive(1'b0, 1'b1, '0, '0, '0);
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 8'hA1, 5'd1, 32'hAAAA_0001);
    step();
    drive(1'b1, 1'b0, 8'hB2, 5'd2, 32'hBBBB_0002);
    step();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hAAAA_0001 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_full: occ=%0d ready=%b data=%h valid=%b, want 2 0 aaaa0001 1",
               occupancy, in_ready, out_data, out_valid);
    end
    // in_valid held high while full must not sneak a third beat in.
    drive(1'b1, 1'b0, 8'hCC, 5'd3, 32'hCCCC_0003);
    step();
    checks++;
    if (occupancy !== 2'd2 || out_data !== 32'hAAAA_0001 || out_ctrl !== 8'hA1) begin
      errors++;
      $display("FAIL stall_hold: occ=%0d data=%h ctrl=%h, want 2 aaaa0001 a1", occupancy, out_data, out_ctrl);
    end
    drive(1'b0, 1'b1, '0, '0, '0);
    step();
    checks++;
    if (occupancy !== 2'd1 || out_data !== 32'hBBBB_0002 || out_ctrl !== 8'hB2 ||
        out_rd !== 5'd2 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_pop_a: occ=%0d data=%h ctrl=%h rd=%0d ready=%b, want 1 bbbb0002 b2 2 1",
               occupancy, out_data, out_ctrl, out_rd, in_ready);
    end
    step();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL stall_pop_b: occ=%0d valid=%b ctrl=%h data=%h, want 0 0 00 0",
               occupancy, out_valid, out_ctrl, out_data);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b0, 8'h11, 5'd4, 32'h1111);
    step();
    drive(1'b1, 1'b0, 8'h22, 5'd5, 32'h2222);
    step();
    drive(1'b1, 1'b1, 8'h33, 5'd6, 32'h3333);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || out_rd !== '0 ||
        in_ready !== 1'b1 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush: valid=%b ctrl=%h data=%h rd=%0d ready=%b occ=%0d, want 0 00 0 0 1 0",
               out_valid, out_ctrl, out_data, out_rd, in_ready, occupancy);
    end
    drive(1'b0, 1'b1, '0, '0, '0);
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush_empty: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 8'h77, 5'd7, 32'h7777);
    step();
    drive(1'b0, 1'b0, '0, '0, '0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 ||
        out_ctrl !== '0 || out_data !== '0 || out_rd !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b ready=%b occ=%0d ctrl=%h data=%h rd=%0d, want 0 1 0 0 0 0",
               out_valid, in_ready, occupancy, out_ctrl, out_data, out_rd);
    end
    @(negedge clock);
    reset = 1'b1;
    step();
    drive(1'b1, 1'b1, 8'h05, 5'd5, 32'h5);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h5 || out_ctrl !== 8'h05 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL post_reset_push: valid=%b data=%h ctrl=%h occ=%0d, want 1 5 05 1",
               out_valid, out_data, out_ctrl, occupancy);
    end
    drive(1'b0, 1'b1, '0, '0, '0);
    step();
  endtask

  // Scoreboard: random handshakes, every popped beat must match the oldest pushed one.
  task automatic test_random();
    logic [PW-1:0] beat;
    logic          push, pop;
    exp_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(1, 255)), 5'($urandom_range(0, 31)), $urandom());
      checks++;
      if (occupancy !== 2'(exp_q.size()) || in_ready !== (exp_q.size() < 2) ||
          out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL rand_state@%0d: occ=%0d ready=%b valid=%b, want occ=%0d",
                 cyc, occupancy, in_ready, out_valid, exp_q.size());
      end
      if (!out_valid) begin
        checks++;
        if (out_ctrl !== '0 || out_data !== '0) begin
          errors++;
          $display("FAIL rand_bubble@%0d: ctrl=%h data=%h, want 0 0", cyc, out_ctrl, out_data);
        end
      end
      push = in_valid && (exp_q.size() < 2);
      pop  = out_ready && (exp_q.size() != 0);
      if (pop) begin
        beat = exp_q.pop_front();
        checks++;
        if ({out_ctrl, out_rd, out_data} !== beat) begin
          errors++;
          $display("FAIL rand_order@%0d: got %h, want %h", cyc, {out_ctrl, out_rd, out_data}, beat);
        end
      end
      if (push) exp_q.push_back({in_ctrl, in_rd, in_data});
      step();
    end
    drive(1'b0, 1'b1, '0, '0, '0);
    step();
    step();
    checks++;
    if (occupancy !== 2'd0) begin
      errors++;
      $display("FAIL rand_drain: occ=%0d, want 0", occupancy);
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: width of the datapath payload (ALU result, operands).
REQ-002 SHALL provide parameter CTRL_W, default 8: width of the control-signal bundle (RegWrite, MemToReg, WREN, RDEN, ...).
REQ-003 SHALL provide parameter RD_W, default 5: width of the destination-register field.
REQ-004 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous squash from the controller.
REQ-007 SHALL have port in_valid  input  1  upstream stage presents a beat.
REQ-008 SHALL have port in_ready  output  1  stage can accept a beat; driven directly from a register.
REQ-009 SHALL have ports in_ctrl/in_rd/in_data  input  CTRL_W/RD_W/DATA_W  upstream payload.
REQ-010 SHALL have port out_valid  output  1  a beat is presented downstream.
REQ-011 SHALL have port out_ready  input  1  downstream stage accepts the beat (stall when 0).
REQ-012 SHALL have ports out_ctrl/out_rd/out_data  output  CTRL_W/RD_W/DATA_W  downstream payload.
REQ-013 SHALL have port occupancy  output  2  number of held beats (0..2).

Function
REQ-014 The stage SHALL be a 2-entry skid buffer with a main register (drives outputs) and a skid register; states EMPTY, ONE, TWO.
REQ-015 Push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated on the same edge.
REQ-016 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO; out_valid SHALL be 1 in ONE and TWO.
REQ-017 EMPTY: push -> main <= input, ONE; otherwise stay EMPTY.
REQ-018 ONE: push & pop -> main <= input, ONE; push only -> skid <= input, TWO; pop only -> EMPTY; neither -> hold.
REQ-019 TWO: pop -> main <= skid, skid cleared, ONE; no pop -> hold all registers.
REQ-020 Latency SHALL be exactly 1 cycle from push into EMPTY to out_valid=1; full throughput (1 beat/cycle) SHALL hold while out_ready=1.
REQ-021 Beats SHALL leave in push order; none SHALL be duplicated or dropped except by flush.
REQ-022 When the stage enters EMPTY, main register SHALL be cleared to all-zero, so out_ctrl=0 (bubble) whenever out_valid=0.
REQ-023 flush SHALL take priority over push and pop: next state EMPTY, main and skid cleared to 0, in_ready=1, occupancy=0.
REQ-024 A beat pushed or popped in the flush cycle SHALL be discarded; the downstream stage SHALL treat the popped beat as accepted.
REQ-025 occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO, registered.
REQ-026 Payload registers SHALL not change while in TWO without pop (stall holds data stable).

Reset
REQ-027 reset=0 SHALL immediately force EMPTY: out_valid=0, in_ready=1, occupancy=0, out_ctrl/out_rd/out_data=0, skid=0.
REQ-028 Reset asserted mid-transfer SHALL discard all held beats; first push after deassertion SHALL behave as REQ-017.

Structure
REQ-029 The state encoding (EMPTY=0, ONE=1, TWO=2) and the default widths SHALL live in shared package mips_pipe_pkg for reuse by all IF/ID, ID/EX, EX/MEM and MEM/WB instances.
REQ-030 No sub-module SHALL be used; one state register plus two payload registers in a single module.

Verification
REQ-031 Reset then push ctrl=8'h0F rd=5'd9 data=32'hDEADBEEF with out_ready=1 -> next cycle out_valid=1 with that payload, in_ready=1, occupancy=1.
REQ-032 Streaming pushes data=1,2,3,4 on consecutive cycles, out_ready=1 -> outputs 1,2,3,4 on consecutive cycles, in_ready never 0.
REQ-033 out_ready=0, push data=A,B -> occupancy=2, in_ready=0, out_data=A held; out_ready=1 for 2 cycles -> A then B, occupancy back to 0, out_ctrl=0.
REQ-034 Occupancy 2, assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl/out_data=0, in_ready=1, both beats and input lost.
REQ-035 Occupancy 1, drive reset=0 asynchronously between edges -> outputs zero before next edge; after release push data=32'h5 -> out 1 cycle later.
REQ-036 Random in_valid/out_ready for 10000 cycles against a scoreboard FIFO -> zero ordering/loss errors and out_ctrl=0 whenever out_valid=0.
